// File: rtl/sand_drop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sand_drop_sequencer
// Description : Write-side driver for the sand array's frame/drop input.
//               Divides VGA vsync pulses down to array frame triggers, keeps
//               a small FIFO of host drop requests, and starts exactly one
//               array frame per trigger. It then waits for frame_done_i, or
//               for a timeout, before it starts the next frame.
//
//   Ports
//     clk, rst        clock (rising edge), synchronous active-high reset
//     vsync_i         one-cycle pulse at each VGA frame start
//     frame_done_i    array finished current frame (level or pulse)
//     resolution_i    active grid edge, 1..MAX_SIZE (0 is treated as 1)
//     auto_en_i       drop automatically when the FIFO is empty
//     req_valid_i     host drop request valid
//     req_ready_o     FIFO not full (from the registered count)
//     req_x_i/req_y_i host drop coordinates
//     new_frame_o     one-cycle frame start pulse
//     drop_o          drop valid, only together with new_frame_o
//     drop_x_o/y_o    drop coordinates, clamped below the resolution
//     busy_o          frame in progress (START or WAIT_DONE)
//     timeout_o       sticky flag: the array failed to report done in time
//     drop_count_o    number of drops issued, wraps at 16 bits
//
//   Build option
//     SAND_DROP_LFSR_EN : the auto source takes pseudo-random coordinates
//                         from a 16-bit LFSR instead of the grid centre.
//
// Revision    : 1.0  initial release
// ============================================================================
module sand_drop_sequencer #(
  parameter int MAX_SIZE     = 32,
  parameter int COORD_W      = 9,
  parameter int FRAME_DIV    = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vsync_i,
  input  logic               frame_done_i,
  input  logic [COORD_W-1:0] resolution_i,
  input  logic               auto_en_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [COORD_W-1:0] req_x_i,
  input  logic [COORD_W-1:0] req_y_i,
  output logic               new_frame_o,
  output logic               drop_o,
  output logic [COORD_W-1:0] drop_x_o,
  output logic [COORD_W-1:0] drop_y_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic [15:0]        drop_count_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam int c_div_w = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int c_tmr_w = $clog2(DONE_TIMEOUT + 1);

  localparam logic [COORD_W-1:0] c_max_size  = COORD_W'(MAX_SIZE);
  localparam logic [COORD_W-1:0] c_one       = COORD_W'(1);
  localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_div_w-1:0] c_div_last  = c_div_w'(FRAME_DIV - 1);
  localparam logic [c_tmr_w-1:0] c_tmr_last  = c_tmr_w'(DONE_TIMEOUT - 1);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_start = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [c_div_w-1:0]  r_div;
  logic                r_trig_pend;
  logic [c_tmr_w-1:0]  r_timer;

  logic [COORD_W-1:0]  r_fifo_x [FIFO_DEPTH];
  logic [COORD_W-1:0]  r_fifo_y [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;

  logic                r_new_frame;
  logic                r_drop;
  logic [COORD_W-1:0]  r_drop_x;
  logic [COORD_W-1:0]  r_drop_y;
  logic                r_timeout;
  logic [15:0]         r_drop_count;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [COORD_W-1:0]  w_res_eff;
  logic [COORD_W-1:0]  w_res_m1;
  logic                w_fifo_empty;
  logic                w_fifo_full;
  logic                w_push;
  logic                w_start;
  logic                w_pop;
  logic                w_div_tick;
  logic [COORD_W-1:0]  w_head_x;
  logic [COORD_W-1:0]  w_head_y;
  logic [COORD_W-1:0]  w_auto_x;
  logic [COORD_W-1:0]  w_auto_y;

  // Limit any coordinate to lim (= effective resolution - 1).
  function automatic logic [COORD_W-1:0] f_clamp(
    input logic [COORD_W-1:0] coord,
    input logic [COORD_W-1:0] lim
  );
    return (coord > lim) ? lim : coord;
  endfunction

  // A resolution of 0 would give an empty grid, so it is treated as 1. A
  // resolution above MAX_SIZE is limited to MAX_SIZE so that drops never
  // land outside the physical array.
  always_comb begin
    w_res_eff = resolution_i;
    if (resolution_i == '0) begin
      w_res_eff = c_one;
    end else if (resolution_i > c_max_size) begin
      w_res_eff = c_max_size;
    end
  end

  assign w_res_m1     = w_res_eff - c_one;

  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == c_depth);

  // Ready comes from the registered count alone, so a full FIFO refuses a
  // push even on the cycle in which an entry is popped.
  assign req_ready_o  = ~w_fifo_full;
  assign w_push       = req_valid_i & ~w_fifo_full;

  // The frame source is selected as IDLE hands over to START, so the drop
  // registers are valid for exactly the START cycle.
  assign w_start      = (r_state == c_st_idle) & r_trig_pend;
  assign w_pop        = w_start & ~w_fifo_empty;

  assign w_div_tick   = vsync_i & (r_div == c_div_last);

  assign w_head_x     = r_fifo_x[r_rd_ptr];
  assign w_head_y     = r_fifo_y[r_rd_ptr];

`ifdef SAND_DROP_LFSR_EN
  // --------------------------------------------------------------------------
  // Pseudo-random auto source
  // --------------------------------------------------------------------------
  logic [15:0]        r_lfsr;
  logic               w_lfsr_fb;
  logic [COORD_W-1:0] w_rnd_x;
  logic [COORD_W-1:0] w_rnd_y;

  // A raw value up to twice the resolution wraps once; anything larger is
  // clamped to the last column/row.
  function automatic logic [COORD_W-1:0] f_fold(
    input logic [COORD_W-1:0] coord,
    input logic [COORD_W-1:0] res,
    input logic [COORD_W-1:0] lim
  );
    logic [COORD_W-1:0] v;
    v = (coord >= res) ? (coord - res) : coord;
    return f_clamp(v, lim);
  endfunction

  // Fibonacci taps 16,14,13,11.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_rnd_x  = r_lfsr[COORD_W-1:0];
  assign w_rnd_y  = r_lfsr[15:16-COORD_W];
  assign w_auto_x = f_fold(w_rnd_x, w_res_eff, w_res_m1);
  assign w_auto_y = f_fold(w_rnd_y, w_res_eff, w_res_m1);
`else
  // The grid centre is always inside the grid, because res >> 1 < res.
  assign w_auto_x = w_res_eff >> 1;
  assign w_auto_y = w_res_eff >> 1;
`endif

  // --------------------------------------------------------------------------
  // FIFO storage. It needs no reset: the pointers and the count alone decide
  // which entries are valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_x[r_wr_ptr] <= req_x_i;
      r_fifo_y[r_wr_ptr] <= req_y_i;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // vsync divider and single-entry trigger latch. The divider keeps counting
  // while a frame is busy. A second trigger that arrives while one is still
  // pending is absorbed, because the latch holds at most one.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_trig_pend <= 1'b0;
    end else begin
      if (vsync_i) begin
        r_div <= w_div_tick ? '0 : (r_div + c_div_w'(1));
      end
      // A trigger that is set on the same cycle the old one is consumed
      // becomes the new pending trigger.
      if (w_div_tick) begin
        r_trig_pend <= 1'b1;
      end else if (w_start) begin
        r_trig_pend <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencing FSM and outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_st_idle;
      r_timer      <= '0;
      r_new_frame  <= 1'b0;
      r_drop       <= 1'b0;
      r_drop_x     <= '0;
      r_drop_y     <= '0;
      r_timeout    <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_new_frame <= 1'b0;
      r_drop      <= 1'b0;

      if (r_drop) begin
        r_drop_count <= r_drop_count + 16'd1;
      end

      case (r_state)
        c_st_idle: begin
          if (r_trig_pend) begin
            r_state     <= c_st_start;
            r_new_frame <= 1'b1;
            // Queued host requests take priority over the auto source.
            // They are clamped now rather than at push time, so that a
            // resolution change in between is still honoured.
            if (!w_fifo_empty) begin
              r_drop   <= 1'b1;
              r_drop_x <= f_clamp(w_head_x, w_res_m1);
              r_drop_y <= f_clamp(w_head_y, w_res_m1);
            end else if (auto_en_i) begin
              r_drop   <= 1'b1;
              r_drop_x <= f_clamp(w_auto_x, w_res_m1);
              r_drop_y <= f_clamp(w_auto_y, w_res_m1);
            end
          end
        end

        c_st_start: begin
          r_state <= c_st_wait;
          r_timer <= '0;
        end

        c_st_wait: begin
          // WAIT_DONE lasts at most DONE_TIMEOUT cycles. If done arrives on
          // the last cycle it wins over the timeout.
          if (frame_done_i) begin
            r_state <= c_st_idle;
          end else if (r_timer == c_tmr_last) begin
            r_state   <= c_st_idle;
            r_timeout <= 1'b1;
          end else begin
            r_timer <= r_timer + c_tmr_w'(1);
          end
        end

        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign new_frame_o  = r_new_frame;
  assign drop_o       = r_drop;
  assign drop_x_o     = r_drop_x;
  assign drop_y_o     = r_drop_y;
  assign busy_o       = (r_state == c_st_start) | (r_state == c_st_wait);
  assign timeout_o    = r_timeout;
  assign drop_count_o = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_sand_drop_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sand_drop_sequencer
// Description : Directed self-checking bench for sand_drop_sequencer. It uses
//               FRAME_DIV=4, FIFO_DEPTH=4, DONE_TIMEOUT=16 and
//               hand-computed expected values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sand_drop_sequencer;

  localparam int COORD_W = 9;

  logic               clk = 1'b0;
  logic               rst;
  logic               vsync_i;
  logic               frame_done_i;
  logic [COORD_W-1:0] resolution_i;
  logic               auto_en_i;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [COORD_W-1:0] req_x_i;
  logic [COORD_W-1:0] req_y_i;
  logic               new_frame_o;
  logic               drop_o;
  logic [COORD_W-1:0] drop_x_o;
  logic [COORD_W-1:0] drop_y_o;
  logic               busy_o;
  logic               timeout_o;
  logic [15:0]        drop_count_o;

  int n_chk    = 0;
  int n_err    = 0;
  int n_frames = 0;
  int nf_base;

  logic               cap_drop;
  logic [COORD_W-1:0] cap_x;
  logic [COORD_W-1:0] cap_y;

  always #5 clk = ~clk;

  sand_drop_sequencer #(
    .MAX_SIZE     (32),
    .COORD_W      (COORD_W),
    .FRAME_DIV    (4),
    .FIFO_DEPTH   (4),
    .DONE_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .vsync_i      (vsync_i),
    .frame_done_i (frame_done_i),
    .resolution_i (resolution_i),
    .auto_en_i    (auto_en_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_x_i      (req_x_i),
    .req_y_i      (req_y_i),
    .new_frame_o  (new_frame_o),
    .drop_o       (drop_o),
    .drop_x_o     (drop_x_o),
    .drop_y_o     (drop_y_o),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .drop_count_o (drop_count_o)
  );

  // Count new_frame pulses between clock edges.
  always @(negedge clk) begin
    if (new_frame_o) n_frames++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_vsync();
    vsync_i = 1'b1;
    step(1);
    vsync_i = 1'b0;
    step(1);
  endtask

  task automatic push(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    req_valid_i = 1'b1;
    req_x_i     = x;
    req_y_i     = y;
    step(1);
    req_valid_i = 1'b0;
  endtask

  // Send FRAME_DIV vsync pulses and stop on the new_frame cycle.
  task automatic trigger();
    for (int i = 0; i < 4; i++) pulse_vsync();
    for (int i = 0; i < 40; i++) begin
      if (new_frame_o) break;
      step(1);
    end
    check("new_frame_seen", 32'(new_frame_o), 32'd1);
    cap_drop = drop_o;
    cap_x    = drop_x_o;
    cap_y    = drop_y_o;
  endtask

  // Assert frame_done 5 cycles after new_frame, then let the FSM settle.
  task automatic finish_frame();
    step(5);
    frame_done_i = 1'b1;
    step(1);
    frame_done_i = 1'b0;
    step(2);
  endtask

  task automatic frame();
    trigger();
    finish_frame();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    vsync_i      = 1'b0;
    frame_done_i = 1'b0;
    resolution_i = 9'd32;
    auto_en_i    = 1'b0;
    req_valid_i  = 1'b0;
    req_x_i      = '0;
    req_y_i      = '0;

    // ---- reset values
    step(3);
    check("rst_new_frame", 32'(new_frame_o), 32'd0);
    check("rst_drop", 32'(drop_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    check("rst_count", 32'(drop_count_o), 32'd0);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    rst = 1'b0;
    step(1);

    // ---- 8 vsync pulses give 2 frames, with no drop while auto is off
    nf_base = n_frames;
    frame();
    check("t1_drop0", 32'(cap_drop), 32'd0);
    frame();
    check("t1_drop1", 32'(cap_drop), 32'd0);
    check("t1_frames", 32'(n_frames - nf_base), 32'd2);

    // ---- FIFO entries first (the second one clamped), then auto centre
    auto_en_i = 1'b1;
    push(9'd3, 9'd7);
    push(9'd40, 9'd2);
    frame();
    check("t2_d0", 32'(cap_drop), 32'd1);
    check("t2_x0", 32'(cap_x), 32'd3);
    check("t2_y0", 32'(cap_y), 32'd7);
    frame();
    check("t2_d1", 32'(cap_drop), 32'd1);
    check("t2_x1", 32'(cap_x), 32'd31);
    check("t2_y1", 32'(cap_y), 32'd2);
    frame();
    check("t2_d2", 32'(cap_drop), 32'd1);
    check("t2_x2", 32'(cap_x), 32'd16);
    check("t2_y2", 32'(cap_y), 32'd16);
    check("t2_count", 32'(drop_count_o), 32'd3);

    // ---- full FIFO refuses the 5th request; order is kept on drain
    auto_en_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t3_ready_before", 32'(req_ready_o), 32'd1);
      push(9'(2 * i + 1), 9'(2 * i + 2));
    end
    check("t3_full_ready", 32'(req_ready_o), 32'd0);
    push(9'd9, 9'd9);
    check("t3_still_full", 32'(req_ready_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      frame();
      check("t3_drain_drop", 32'(cap_drop), 32'd1);
      check("t3_drain_x", 32'(cap_x), 32'(2 * i + 1));
      check("t3_drain_y", 32'(cap_y), 32'(2 * i + 2));
    end
    frame();
    check("t3_fifth_absent", 32'(cap_drop), 32'd0);
    check("t3_count", 32'(drop_count_o), 32'd7);

    // ---- resolution 0 is treated as 1, so every drop lands at (0,0)
    resolution_i = 9'd0;
    push(9'd5, 9'd5);
    frame();
    check("t_res0_drop", 32'(cap_drop), 32'd1);
    check("t_res0_x", 32'(cap_x), 32'd0);
    check("t_res0_y", 32'(cap_y), 32'd0);
    resolution_i = 9'd32;

    // ---- timeout: WAIT_DONE lasts exactly 16 cycles
    trigger();
    check("t4_busy_start", 32'(busy_o), 32'd1);
    step(16);
    check("t4_busy_last", 32'(busy_o), 32'd1);
    check("t4_timeout_early", 32'(timeout_o), 32'd0);
    step(1);
    check("t4_busy_fall", 32'(busy_o), 32'd0);
    check("t4_timeout_set", 32'(timeout_o), 32'd1);
    step(2);
    frame();
    check("t4_timeout_sticky", 32'(timeout_o), 32'd1);

    // ---- 8 extra vsync pulses while busy leave one pending trigger
    nf_base = n_frames;
    trigger();
    vsync_i = 1'b1;
    step(8);
    vsync_i = 1'b0;
    frame_done_i = 1'b1;
    step(1);
    frame_done_i = 1'b0;
    check("t5_idle_after_done", 32'(busy_o), 32'd0);
    step(1);
    check("t5_pending_served", 32'(new_frame_o), 32'd1);
    finish_frame();
    step(30);
    check("t5_frames", 32'(n_frames - nf_base), 32'd2);

    // ---- reset mid-frame with 2 entries queued
    check("t6_count_before", 32'(drop_count_o), 32'd8);
    trigger();
    push(9'd1, 9'd1);
    push(9'd2, 9'd2);
    check("t6_busy_before", 32'(busy_o), 32'd1);
    rst = 1'b1;
    step(1);
    check("t6_busy", 32'(busy_o), 32'd0);
    check("t6_count", 32'(drop_count_o), 32'd0);
    check("t6_ready", 32'(req_ready_o), 32'd1);
    check("t6_timeout", 32'(timeout_o), 32'd0);
    rst = 1'b0;
    step(1);
    frame();
    check("t6_fifo_empty", 32'(cap_drop), 32'd0);

    // ---- with resolution 20, auto drops stay inside the grid
    resolution_i = 9'd20;
    auto_en_i    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frame();
      check("t7_drop", 32'(cap_drop), 32'd1);
      check("t7_x_in_range", 32'(cap_x < 9'd20), 32'd1);
      check("t7_y_in_range", 32'(cap_y < 9'd20), 32'd1);
`ifndef SAND_DROP_LFSR_EN
      check("t7_x_centre", 32'(cap_x), 32'd10);
      check("t7_y_centre", 32'(cap_y), 32'd10);
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
